// File: rtl/max_registers.sv
// max_registers: running-maximum tracker for the local-alignment score matrix.
// Each enabled cycle, a wavefront of COMPARE_UNITS_LVL_1 x NUM_VALS_LVL_1
// candidate scores (with row/col coordinates) is reduced to a single winner.
// The winner replaces the held best-so-far only if it is strictly larger.
// Ties resolve to the earliest candidate in flat order (u*N+v).
// Ties with the held value keep the held entry.
module max_registers #(
  parameter int unsigned COMPARE_UNITS_LVL_1 = 4,
  parameter int unsigned NUM_VALS_LVL_1      = 4,
  parameter int unsigned SCORE_WIDTH         = 8,
  parameter int unsigned ROW_BITS_WIDTH      = 5,
  parameter int unsigned COL_BITS_WIDTH      = 5
) (
  input  logic                                                         clk,
  input  logic                                                         rst_n,
  input  logic                                                         wr_en_max,
  input  logic [COMPARE_UNITS_LVL_1-1:0][NUM_VALS_LVL_1-1:0][SCORE_WIDTH-1:0]    score_in,
  input  logic [COMPARE_UNITS_LVL_1-1:0][NUM_VALS_LVL_1-1:0][ROW_BITS_WIDTH-1:0] row_in,
  input  logic [COMPARE_UNITS_LVL_1-1:0][NUM_VALS_LVL_1-1:0][COL_BITS_WIDTH-1:0] col_in,
  output logic [SCORE_WIDTH-1:0]                                       max_score,
  output logic [ROW_BITS_WIDTH-1:0]                                    max_row,
  output logic [COL_BITS_WIDTH-1:0]                                    max_col
);

  // Per-group winners from the first compare level
  logic [SCORE_WIDTH-1:0]    w_grp_score [COMPARE_UNITS_LVL_1];
  logic [ROW_BITS_WIDTH-1:0] w_grp_row   [COMPARE_UNITS_LVL_1];
  logic [COL_BITS_WIDTH-1:0] w_grp_col   [COMPARE_UNITS_LVL_1];

  // Overall winner from the second compare level
  logic [SCORE_WIDTH-1:0]    w_best_score;
  logic [ROW_BITS_WIDTH-1:0] w_best_row;
  logic [COL_BITS_WIDTH-1:0] w_best_col;

  // Held best-so-far
  logic [SCORE_WIDTH-1:0]    r_max_score;
  logic [ROW_BITS_WIDTH-1:0] r_max_row;
  logic [COL_BITS_WIDTH-1:0] r_max_col;

  // Level 1: max within each group; strict compare keeps the lowest value index on ties
  always_comb begin
    for (int unsigned u = 0; u < COMPARE_UNITS_LVL_1; u++) begin
      w_grp_score[u] = score_in[u][0];
      w_grp_row[u]   = row_in[u][0];
      w_grp_col[u]   = col_in[u][0];
      for (int unsigned v = 1; v < NUM_VALS_LVL_1; v++) begin
        if (score_in[u][v] > w_grp_score[u]) begin
          w_grp_score[u] = score_in[u][v];
          w_grp_row[u]   = row_in[u][v];
          w_grp_col[u]   = col_in[u][v];
        end
      end
    end
  end

  // Level 2: max across group winners; strict compare keeps the lowest group index on ties
  always_comb begin
    w_best_score = w_grp_score[0];
    w_best_row   = w_grp_row[0];
    w_best_col   = w_grp_col[0];
    for (int unsigned u = 1; u < COMPARE_UNITS_LVL_1; u++) begin
      if (w_grp_score[u] > w_best_score) begin
        w_best_score = w_grp_score[u];
        w_best_row   = w_grp_row[u];
        w_best_col   = w_grp_col[u];
      end
    end
  end

  // Best-so-far register: reset wins, then merge only on a strictly larger winner
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_max_score <= '0;
      r_max_row   <= '0;
      r_max_col   <= '0;
    end else if (wr_en_max && (w_best_score > r_max_score)) begin
      r_max_score <= w_best_score;
      r_max_row   <= w_best_row;
      r_max_col   <= w_best_col;
    end
  end

  assign max_score = r_max_score;
  assign max_row   = r_max_row;
  assign max_col   = r_max_col;

endmodule

// File: tb/tb_max_registers.sv
// Directed bench for max_registers: reset, merge, hold, tie-break and
// mid-operation reset scenarios with hand-computed expected outputs.
module tb_max_registers;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   wr_en_max;
  logic [3:0][3:0][7:0]   score_in;
  logic [3:0][3:0][4:0]   row_in;
  logic [3:0][3:0][4:0]   col_in;
  logic [7:0]             max_score;
  logic [4:0]             max_row;
  logic [4:0]             max_col;

  int unsigned total  = 0;
  int unsigned passed = 0;

  max_registers #(
    .COMPARE_UNITS_LVL_1(4),
    .NUM_VALS_LVL_1     (4),
    .SCORE_WIDTH        (8),
    .ROW_BITS_WIDTH     (5),
    .COL_BITS_WIDTH     (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_max(wr_en_max),
    .score_in (score_in),
    .row_in   (row_in),
    .col_in   (col_in),
    .max_score(max_score),
    .max_row  (max_row),
    .max_col  (max_col)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, want completion");
    $fatal(1);
  end

  // One rising edge, then settle 1 time unit past it before sampling/driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flat index i = u*4+v gets row = i+10, col = 31-i; g0[2] and g2[3] overridden
  task automatic init_coords();
    for (int u = 0; u < 4; u++)
      for (int v = 0; v < 4; v++) begin
        row_in[u][v] = 5'(u*4 + v + 10);
        col_in[u][v] = 5'(31 - (u*4 + v));
      end
    row_in[0][2] = 5'd1; col_in[0][2] = 5'd0;
    row_in[2][3] = 5'd6; col_in[2][3] = 5'd1;
  endtask

  task automatic set_group(input int u, input logic [7:0] a, b, c, d);
    score_in[u][0] = a;
    score_in[u][1] = b;
    score_in[u][2] = c;
    score_in[u][3] = d;
  endtask

  task automatic apply_set_a();
    set_group(0, 1, 8, 13, 3);
    set_group(1, 5, 11, 3, 8);
    set_group(2, 8, 1, 7, 4);
    set_group(3, 3, 9, 4, 7);
  endtask

  task automatic apply_set_b();
    set_group(0, 2, 7, 12, 5);
    set_group(1, 4, 8, 8, 4);
    set_group(2, 7, 11, 1, 15);
    set_group(3, 3, 4, 9, 7);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    for (int u = 0; u < 4; u++)
      for (int v = 0; v < 4; v++) begin
        score_in[u][v] = 8'($urandom_range(1, 255));
        row_in[u][v]   = 5'($urandom);
        col_in[u][v]   = 5'($urandom);
      end
    wr_en_max = 1'b1;
    rst_n = 1'b1;
    tick();
    tick();
    total++;
    if ({max_score, max_row, max_col} !== {8'd0, 5'd0, 5'd0})
      $display("FAIL reset: got %0d/%0d/%0d want 0/0/0", max_score, max_row, max_col);
    else passed++;
    rst_n = 1'b0;
    init_coords();
    // All-zero candidates must not displace the reset state
    for (int u = 0; u < 4; u++) set_group(u, 0, 0, 0, 0);
    tick();
    total++;
    if ({max_score, max_row, max_col} !== {8'd0, 5'd0, 5'd0})
      $display("FAIL all_zero: got %0d/%0d/%0d want 0/0/0", max_score, max_row, max_col);
    else passed++;
  endtask

  task automatic test_merge();
    apply_set_a();
    tick();
    total++;
    if ({max_score, max_row, max_col} !== {8'd13, 5'd1, 5'd0})
      $display("FAIL set_a: got %0d/%0d/%0d want 13/1/0", max_score, max_row, max_col);
    else passed++;
    apply_set_b();
    tick();
    total++;
    if ({max_score, max_row, max_col} !== {8'd15, 5'd6, 5'd1})
      $display("FAIL set_b: got %0d/%0d/%0d want 15/6/1", max_score, max_row, max_col);
    else passed++;
    apply_set_a();
    tick();
    total++;
    if ({max_score, max_row, max_col} !== {8'd15, 5'd6, 5'd1})
      $display("FAIL no_decrease: got %0d/%0d/%0d want 15/6/1", max_score, max_row, max_col);
    else passed++;
  endtask

  task automatic test_enable_low();
    wr_en_max = 1'b0;
    for (int u = 0; u < 4; u++) set_group(u, 255, 255, 255, 255);
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({max_score, max_row, max_col} !== {8'd15, 5'd6, 5'd1})
        $display("FAIL enable_low_%0d: got %0d/%0d/%0d want 15/6/1", k, max_score, max_row, max_col);
      else passed++;
    end
    wr_en_max = 1'b1;
    tick();
    // g0[0]: row 10, col 31
    total++;
    if ({max_score, max_row, max_col} !== {8'd255, 5'd10, 5'd31})
      $display("FAIL enable_max255: got %0d/%0d/%0d want 255/10/31", max_score, max_row, max_col);
    else passed++;
  endtask

  task automatic test_ties();
    do_reset();
    apply_set_b();
    tick();
    total++;
    if ({max_score, max_row, max_col} !== {8'd15, 5'd6, 5'd1})
      $display("FAIL tie_setup: got %0d/%0d/%0d want 15/6/1", max_score, max_row, max_col);
    else passed++;
    // Max 15 only at g3[1] (row 23, col 18): equal to held, so held coords stay
    set_group(0, 3, 4, 5, 6);
    set_group(1, 7, 8, 9, 10);
    set_group(2, 11, 12, 13, 14);
    set_group(3, 2, 15, 1, 0);
    tick();
    total++;
    if ({max_score, max_row, max_col} !== {8'd15, 5'd6, 5'd1})
      $display("FAIL tie_held: got %0d/%0d/%0d want 15/6/1", max_score, max_row, max_col);
    else passed++;
    // Equal maxima at g1[3] (row 17, col 24) and g2[0] (row 18, col 23)
    do_reset();
    set_group(0, 1, 2, 3, 4);
    set_group(1, 5, 6, 7, 20);
    set_group(2, 20, 9, 10, 11);
    set_group(3, 12, 13, 14, 19);
    tick();
    total++;
    if ({max_score, max_row, max_col} !== {8'd20, 5'd17, 5'd24})
      $display("FAIL tie_in_set: got %0d/%0d/%0d want 20/17/24", max_score, max_row, max_col);
    else passed++;
    // Within-group tie only: g2[1] and g2[2] both 30, g2[1] is row 19, col 22
    set_group(2, 0, 30, 30, 1);
    tick();
    total++;
    if ({max_score, max_row, max_col} !== {8'd30, 5'd19, 5'd22})
      $display("FAIL tie_in_group: got %0d/%0d/%0d want 30/19/22", max_score, max_row, max_col);
    else passed++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    apply_set_b();
    tick();
    total++;
    if ({max_score, max_row, max_col} !== {8'd15, 5'd6, 5'd1})
      $display("FAIL mid_setup: got %0d/%0d/%0d want 15/6/1", max_score, max_row, max_col);
    else passed++;
    // Candidate 20 at g1[1]: row 15, col 26
    set_group(0, 1, 2, 3, 4);
    set_group(1, 5, 20, 7, 8);
    set_group(2, 9, 10, 11, 12);
    set_group(3, 13, 14, 15, 16);
    wr_en_max = 1'b1;
    rst_n = 1'b1;
    tick();
    total++;
    if ({max_score, max_row, max_col} !== {8'd0, 5'd0, 5'd0})
      $display("FAIL mid_reset: got %0d/%0d/%0d want 0/0/0", max_score, max_row, max_col);
    else passed++;
    rst_n = 1'b0;
    tick();
    total++;
    if ({max_score, max_row, max_col} !== {8'd20, 5'd15, 5'd26})
      $display("FAIL after_reset: got %0d/%0d/%0d want 20/15/26", max_score, max_row, max_col);
    else passed++;
  endtask

  initial begin
    rst_n     = 1'b1;
    wr_en_max = 1'b0;
    score_in  = '0;
    row_in    = '0;
    col_in    = '0;
    #2;
    test_reset();
    test_merge();
    test_enable_low();
    test_ties();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
